vga_sync_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_wrap_counter.sv | 37 +++
 rtl/vga_sync_gen.sv | 108 ++++++++++
 tb/tb_vga_sync_gen.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants, coordinate type and window helper
package vga_timing_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam bit SYNC_POL = 1'b0;

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Half-open window test lo <= v < hi.
    function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// rtl/vga_wrap_counter.sv - 10-bit enabled counter wrapping at MAX, async reset to MAX
module vga_wrap_counter
    import vga_timing_pkg::*;
#(
    parameter coord_t MAX = coord_t'(H_TOTAL - 1)
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en_i,
    output coord_t cnt_o,
    output coord_t cnt_d_o,
    output logic   at_max_o
);

    coord_t cnt_q;
    coord_t cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == MAX) ? '0 : cnt_q + coord_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= MAX;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign cnt_d_o  = cnt_d;
    assign at_max_o = (cnt_q == MAX);

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA timing generator; VGA_FRAME_CNT_EN adds the frame_cnt output
module vga_sync_gen
    import vga_timing_pkg::coord_t;
#(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter bit SYNC_POL = vga_timing_pkg::SYNC_POL
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam coord_t H_MAX   = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t V_MAX   = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t H_ACT   = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT   = coord_t'(V_ACTIVE);
    localparam coord_t HS_LO   = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_HI   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_LO   = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_HI   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    coord_t h_cnt, h_d, v_cnt, v_d;
    logic   h_at_max, v_at_max;

    vga_wrap_counter #(.MAX(H_MAX)) u_h_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (1'b1),
        .cnt_o    (h_cnt),
        .cnt_d_o  (h_d),
        .at_max_o (h_at_max)
    );

    vga_wrap_counter #(.MAX(V_MAX)) u_v_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (h_at_max),
        .cnt_o    (v_cnt),
        .cnt_d_o  (v_d),
        .at_max_o (v_at_max)
    );

    logic active_q, hsync_q, vsync_q, line_start_q, frame_start_q;
    logic frame_start_d;

    // Decoding the next-state counts keeps every flag aligned with the x/y it describes.
    assign frame_start_d = (h_d == '0) && (v_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q      <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            active_q      <= (h_d < H_ACT) && (v_d < V_ACT);
            hsync_q       <= vga_timing_pkg::in_window(h_d, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
            vsync_q       <= vga_timing_pkg::in_window(v_d, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
            line_start_q  <= (h_d == '0);
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    // Starts at FF so the first frame after reset reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 8'hFF;
        end else if (frame_start_d) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign x           = h_cnt;
    assign y           = v_cnt;
    assign active      = active_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

    logic unused_ok;
    assign unused_ok = v_at_max;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed bench: default 640x480 instance plus a shrunk-timing instance
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] x, y, xs, ys;
    logic act, hs, vs, ls, fs;
    logic act_s, hs_s, vs_s, ls_s, fs_s;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] fc, fc_s;
`endif

    vga_sync_gen dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .active(act), .hsync(hs), .vsync(vs),
        .line_start(ls), .frame_start(fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc)
`endif
    );

    // Small frame: 10 pixels x 8 lines, hsync x=5..6, vsync y=4..5, active-high sync.
    vga_sync_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(3),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .x(xs), .y(ys), .active(act_s), .hsync(hs_s), .vsync(vs_s),
        .line_start(ls_s), .frame_start(fs_s)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc_s)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act_v, input int exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
        end
    endtask

    typedef struct {
        int p;
        int ex, ey;
        bit eact, ehs, evs, els, efs;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl[NV];

    task automatic chk_reset_values();
        chk("rst_x", int'(x), 799);
        chk("rst_y", int'(y), 524);
        chk("rst_active", int'(act), 0);
        chk("rst_hsync", int'(hs), 1);
        chk("rst_vsync", int'(vs), 1);
        chk("rst_line_start", int'(ls), 0);
        chk("rst_frame_start", int'(fs), 0);
        chk("rst_s_x", int'(xs), 9);
        chk("rst_s_y", int'(ys), 7);
        chk("rst_s_hsync", int'(hs_s), 0);
        chk("rst_s_vsync", int'(vs_s), 0);
`ifdef VGA_FRAME_CNT_EN
        chk("rst_frame_cnt", int'(fc), 255);
        chk("rst_s_frame_cnt", int'(fc_s), 255);
`endif
    endtask

    task automatic chk_small(input int p);
        int ex, ey;
        ex = p % 10;
        ey = (p / 10) % 8;
        chk("s_x", int'(xs), ex);
        chk("s_y", int'(ys), ey);
        chk("s_active", int'(act_s), int'(ex < 4 && ey < 3));
        chk("s_hsync", int'(hs_s), int'(ex >= 5 && ex < 7));
        chk("s_vsync", int'(vs_s), int'(ey >= 4 && ey < 6));
        chk("s_line_start", int'(ls_s), int'(ex == 0));
        chk("s_frame_start", int'(fs_s), int'(ex == 0 && ey == 0));
`ifdef VGA_FRAME_CNT_EN
        chk("s_frame_cnt", int'(fc_s), (p / 80) % 256);
`endif
    endtask

    initial begin
        int vi;
        int hs_low, vs_cnt, fs_cnt;

        tbl[0]  = '{0,    0,   0, 1, 1, 1, 1, 1};
        tbl[1]  = '{1,    1,   0, 1, 1, 1, 0, 0};
        tbl[2]  = '{639,  639, 0, 1, 1, 1, 0, 0};
        tbl[3]  = '{640,  640, 0, 0, 1, 1, 0, 0};
        tbl[4]  = '{655,  655, 0, 0, 1, 1, 0, 0};
        tbl[5]  = '{656,  656, 0, 0, 0, 1, 0, 0};
        tbl[6]  = '{751,  751, 0, 0, 0, 1, 0, 0};
        tbl[7]  = '{752,  752, 0, 0, 1, 1, 0, 0};
        tbl[8]  = '{799,  799, 0, 0, 1, 1, 0, 0};
        tbl[9]  = '{800,  0,   1, 1, 1, 1, 1, 0};
        tbl[10] = '{801,  1,   1, 1, 1, 1, 0, 0};
        tbl[11] = '{1599, 799, 1, 0, 1, 1, 0, 0};
        tbl[12] = '{1600, 0,   2, 1, 1, 1, 1, 0};
        tbl[13] = '{1900, 300, 2, 1, 1, 1, 0, 0};

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_reset_values();
        rst_n = 1'b1;

        vi = 0;
        hs_low = 0;
        for (int p = 0; p <= 1900; p++) begin
            @(posedge clk);
            #1;
            if (vi < NV && tbl[vi].p == p) begin
                chk($sformatf("x@%0d", p), int'(x), tbl[vi].ex);
                chk($sformatf("y@%0d", p), int'(y), tbl[vi].ey);
                chk($sformatf("active@%0d", p), int'(act), int'(tbl[vi].eact));
                chk($sformatf("hsync@%0d", p), int'(hs), int'(tbl[vi].ehs));
                chk($sformatf("vsync@%0d", p), int'(vs), int'(tbl[vi].evs));
                chk($sformatf("line_start@%0d", p), int'(ls), int'(tbl[vi].els));
                chk($sformatf("frame_start@%0d", p), int'(fs), int'(tbl[vi].efs));
`ifdef VGA_FRAME_CNT_EN
                chk($sformatf("frame_cnt@%0d", p), int'(fc), 0);
`endif
                vi++;
            end
            if (p < 800 && hs == 1'b0) hs_low++;
            if (p < 240) chk_small(p);
        end
        chk("hsync_low_cycles_line0", hs_low, 96);
        chk("vectors_applied", vi, NV);

        // Mid-cycle asynchronous reset: outputs must drop before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_values();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        vs_cnt = 0;
        fs_cnt = 0;
        for (int p = 0; p <= 256 * 80 + 1; p++) begin
            @(posedge clk);
            #1;
            if (p == 0) begin
                chk("restart_x", int'(x), 0);
                chk("restart_y", int'(y), 0);
                chk("restart_frame_start", int'(fs), 1);
            end
            if (p == 800) begin
                chk("restart_line1_y", int'(y), 1);
                chk("restart_line1_ls", int'(ls), 1);
            end
            if (p < 80 && vs_s == 1'b1) vs_cnt++;
            if (p < 800 && fs_s == 1'b1) fs_cnt++;
            if (p < 240 || (p % 80) == 0 || (p % 80) == 79) chk_small(p);
        end
        chk("s_vsync_cycles_frame0", vs_cnt, 20);
        chk("s_frame_start_per_10_frames", fs_cnt, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
